// File: rtl/video_cmd_pkg.sv
// Shared opcodes, FSM states and instruction-FIFO entry layout for video_cmd_dispatcher.
package video_cmd_pkg;

  localparam logic [3:0] OP_WR_REG = 4'h0;
  localparam logic [3:0] OP_WR_MEM = 4'h1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    ISSUE    = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  // Entry layout at the default geometry; the dispatcher rebuilds it from its own parameters.
  localparam int ENTRY_ADDR_W = 14;
  localparam int ENTRY_DATA_W = 32;

  typedef struct packed {
    logic [3:0]              opcode;
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] payload;
  } cmd_entry_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_WR_REG) || (op == OP_WR_MEM);
  endfunction

endpackage

// File: rtl/video_cmd_dispatcher_fifo.sv
// Synchronous instruction FIFO with registered full/empty/level; storage is not reset.
module cmd_fifo #(
  parameter int WIDTH = 50,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/video_cmd_dispatcher.sv
// Buffers CPU instructions and dispatches register/sprite-memory writes outside the print window.
// Optional ack timeout: define VIDEO_CMD_ACK_TIMEOUT_EN.
module video_cmd_dispatcher
  import video_cmd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int REG_AW      = 5,
  parameter int MEM_AW      = 14,
  parameter int COLOR_W     = 9,
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clk_en,
  input  logic [31:0]                   dataA,
  input  logic [DATA_W-1:0]             dataB,
  input  logic                          clr_err,
  input  logic                          printtingScreen,
  input  logic                          reg_ack,
  input  logic                          mem_ack,
  output logic                          reg_wr,
  output logic [REG_AW-1:0]             n_reg,
  output logic [DATA_W-1:0]             reg_data,
  output logic                          mem_wr,
  output logic [MEM_AW-1:0]             mem_addr,
  output logic [COLOR_W-1:0]            mem_data,
  output logic                          selectorAddress,
  output logic                          instr_done,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          err_opcode,
  output logic                          err_overflow,
  output logic                          err_timeout
);

  localparam int ENTRY_W = 4 + MEM_AW + DATA_W;

  typedef struct packed {
    logic [3:0]        opcode;
    logic [MEM_AW-1:0] addr;
    logic [DATA_W-1:0] payload;
  } entry_t;

  entry_t              push_entry, head_entry, cmd_q;
  logic                fifo_empty, fifo_push, fifo_pop;
  state_t              state_q, state_d;
  logic                is_mem, ack_match, go_issue, op_err, to_err;
  logic                reg_wr_q, mem_wr_q, done_q;
  logic [REG_AW-1:0]   n_reg_q;
  logic [DATA_W-1:0]   reg_data_q;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic [COLOR_W-1:0]  mem_data_q;
  logic                err_opcode_q, err_overflow_q;
  logic                unused_dataA;

  assign push_entry   = {dataA[3:0], dataA[4+MEM_AW-1:4], dataB};
  assign unused_dataA = ^dataA[31:4+MEM_AW];

  // fifo_full is registered, so a push against a full FIFO is lost even if a pop happens now.
  assign fifo_push = clk_en && !fifo_full;
  assign fifo_pop  = (state_q == IDLE) && !fifo_empty;

  cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (fifo_pop) cmd_q <= head_entry;
  end

  assign is_mem    = (cmd_q.opcode == OP_WR_MEM);
  assign ack_match = is_mem ? mem_ack : reg_ack;
  assign go_issue  = (state_q == CHECK) && op_legal(cmd_q.opcode) && !printtingScreen;
  assign op_err    = (state_q == CHECK) && !op_legal(cmd_q.opcode);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!fifo_empty) state_d = CHECK;
      CHECK:    if (op_err) state_d = IDLE;
                else if (go_issue) state_d = ISSUE;
      ISSUE:    state_d = WAIT_ACK;
      WAIT_ACK: if (ack_match || to_err) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      reg_wr_q       <= 1'b0;
      mem_wr_q       <= 1'b0;
      done_q         <= 1'b0;
      n_reg_q        <= '0;
      reg_data_q     <= '0;
      mem_addr_q     <= '0;
      mem_data_q     <= '0;
      err_opcode_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      reg_wr_q <= go_issue && !is_mem;
      mem_wr_q <= go_issue && is_mem;
      done_q   <= (state_q == WAIT_ACK) && ack_match;
      if (go_issue && !is_mem) begin
        n_reg_q    <= cmd_q.addr[REG_AW-1:0];
        reg_data_q <= cmd_q.payload;
      end
      if (go_issue && is_mem) begin
        mem_addr_q <= cmd_q.addr;
        mem_data_q <= cmd_q.payload[COLOR_W-1:0];
      end
      // A new error in the same cycle as clr_err keeps the flag set.
      err_opcode_q   <= op_err | (err_opcode_q & ~clr_err);
      err_overflow_q <= (clk_en & fifo_full) | (err_overflow_q & ~clr_err);
    end
  end

`ifdef VIDEO_CMD_ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            err_timeout_q;

  assign to_err      = (state_q == WAIT_ACK) && !ack_match && (to_cnt_q == TO_LAST);
  assign err_timeout = err_timeout_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (state_q == ISSUE)         to_cnt_q <= '0;
      else if (state_q == WAIT_ACK) to_cnt_q <= to_cnt_q + TO_ONE;
      err_timeout_q <= to_err | (err_timeout_q & ~clr_err);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^ACK_TIMEOUT;
  assign to_err         = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  assign reg_wr          = reg_wr_q;
  assign mem_wr          = mem_wr_q;
  assign n_reg           = n_reg_q;
  assign reg_data        = reg_data_q;
  assign mem_addr        = mem_addr_q;
  assign mem_data        = mem_data_q;
  assign instr_done      = done_q;
  assign selectorAddress = is_mem && ((state_q == ISSUE) || (state_q == WAIT_ACK));
  assign busy            = (state_q != IDLE) || (fifo_level != '0);
  assign err_opcode      = err_opcode_q;
  assign err_overflow    = err_overflow_q;

endmodule

// File: tb/tb_video_cmd_dispatcher.sv
// Scoreboard bench for video_cmd_dispatcher: directed stimulus, expected writes queued, monitor compares.
module tb_video_cmd_dispatcher;

  logic        clk;
  logic        reset, clk_en, clr_err, printtingScreen, reg_ack, mem_ack;
  logic [31:0] dataA, dataB;
  logic        reg_wr, mem_wr, selectorAddress, instr_done, fifo_full, busy;
  logic        err_opcode, err_overflow, err_timeout;
  logic [4:0]  n_reg;
  logic [31:0] reg_data;
  logic [13:0] mem_addr;
  logic [8:0]  mem_data;
  logic [3:0]  fifo_level;

  video_cmd_dispatcher #(
    .FIFO_DEPTH(8), .REG_AW(5), .MEM_AW(14), .COLOR_W(9), .DATA_W(32), .ACK_TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .dataA(dataA), .dataB(dataB),
    .clr_err(clr_err), .printtingScreen(printtingScreen), .reg_ack(reg_ack), .mem_ack(mem_ack),
    .reg_wr(reg_wr), .n_reg(n_reg), .reg_data(reg_data), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_data(mem_data), .selectorAddress(selectorAddress), .instr_done(instr_done),
    .fifo_full(fifo_full), .fifo_level(fifo_level), .busy(busy), .err_opcode(err_opcode),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  typedef struct {
    bit          is_mem;
    logic [13:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk = 0, n_fail = 0;
  int   cyc = 0, push_cyc = 0, strobe_cyc = 0, done_cyc = 0;
  int   strobe_cnt = 0, done_cnt = 0, base_done = 0, base_str = 0;
  int   ack_delay = 1, rsp_cnt = 0, n = 0, s_cyc = 0;
  bit   auto_ack = 1, rsp_mem = 0, manual_reg_ack = 0;
  bit          b_mem;
  logic [13:0] b_addr;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input bit m, input logic [13:0] a, input logic [31:0] d);
    exp_t e;
    e.is_mem = m; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    clk_en = 1; dataA = a; dataB = b;
    @(negedge clk);
    clk_en = 0;
    push_cyc = cyc;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, busy, 0);
    @(negedge clk);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_strobes"}, {reg_wr, mem_wr, instr_done, selectorAddress}, 0);
    chk({tag, "_status"}, {fifo_full, busy, err_opcode, err_overflow, err_timeout}, 0);
    chk({tag, "_level"}, fifo_level, 0);
    chk({tag, "_data"}, {n_reg, mem_addr, mem_data}, 0);
    chk({tag, "_reg_data"}, reg_data, 0);
  endtask

  // Ack responder: answers a strobe with the matching ack ack_delay cycles later.
  initial begin
    reg_ack = 0; mem_ack = 0;
    forever begin
      @(negedge clk);
      reg_ack = manual_reg_ack; mem_ack = 0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          if (rsp_mem) mem_ack = 1; else reg_ack = 1;
        end
      end
      if (auto_ack && (reg_wr || mem_wr)) begin
        rsp_cnt = ack_delay;
        rsp_mem = mem_wr;
      end
    end
  end

  // Monitor: every write strobe is checked against the head of the scoreboard.
  initial forever begin
    @(negedge clk);
    if (instr_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (reg_wr || mem_wr) begin
      strobe_cnt++;
      strobe_cyc = cyc;
      if (q.size() == 0) chk("unexpected_strobe", {reg_wr, mem_wr}, 0);
      else begin
        mon_e = q.pop_front();
        chk("strobe_kind", {reg_wr, mem_wr}, mon_e.is_mem ? 2'b01 : 2'b10);
        chk("sel_at_strobe", selectorAddress, mon_e.is_mem);
        if (mon_e.is_mem) begin
          chk("mem_addr", mem_addr, mon_e.addr);
          chk("mem_data", mem_data, mon_e.data[8:0]);
        end else begin
          chk("n_reg", n_reg, mon_e.addr[4:0]);
          chk("reg_data", reg_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; clk_en = 0; clr_err = 0; printtingScreen = 0; dataA = 0; dataB = 0;
    #2 reset = 0;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);

    // Single register write with latency checks.
    base_done = done_cnt;
    exp_push(0, 14'd5, 32'd694310912);
    push(32'h50, 32'd694310912);
    wait_idle(40, "t1_idle");
    chk("t1_strobe_latency", strobe_cyc - push_cyc, 2);
    chk("t1_done_latency", done_cyc - push_cyc, 4);
    chk("t1_done_count", done_cnt - base_done, 1);

    // Memory write held off by the print window.
    printtingScreen = 1; ack_delay = 3; base_done = done_cnt;
    exp_push(1, 14'h3fff, 32'd12);
    push(32'h3fff1, 32'd12);
    base_str = strobe_cnt;
    repeat (20) @(negedge clk);
    chk("t2_no_wr_while_printing", strobe_cnt - base_str, 0);
    chk("t2_busy_while_printing", busy, 1);
    printtingScreen = 0;
    n = 0;
    while (!mem_wr && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t2_mem_wr_seen", mem_wr, 1);
    @(negedge clk);
    chk("t2_mem_wr_single_cycle", mem_wr, 0);
    chk("t2_sel_in_wait", selectorAddress, 1);
    wait_idle(20, "t2_idle");
    chk("t2_sel_after_ack", selectorAddress, 0);
    chk("t2_mem_addr_held", mem_addr, 14'h3fff);
    chk("t2_done_count", done_cnt - base_done, 1);

    // Burst of 10 while one command is parked in CHECK: 8 fit, 2 dropped.
    printtingScreen = 1; ack_delay = 1; base_done = done_cnt;
    exp_push(0, 14'd1, 32'h11111111);
    push(32'h10, 32'h11111111);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      b_mem  = (i % 2) == 1;
      b_addr = b_mem ? (14'h100 + 14'(i)) : (14'd8 + 14'(i));
      clk_en = 1;
      dataA  = {14'd0, b_addr, 3'd0, b_mem};
      dataB  = 32'hA000_0000 + i;
      clr_err = (i == 9);
      if (i < 8) exp_push(b_mem, b_addr, 32'hA000_0000 + i);
      @(negedge clk);
    end
    clk_en = 0; clr_err = 0;
    chk("t3_fifo_full", fifo_full, 1);
    chk("t3_fifo_level", fifo_level, 8);
    chk("t3_err_overflow_set_wins", err_overflow, 1);
    printtingScreen = 0;
    wait_idle(200, "t3_idle");
    chk("t3_done_count", done_cnt - base_done, 9);
    chk("t3_scoreboard_drained", q.size(), 0);

    // Illegal opcode, then a legal command, then clear.
    base_done = done_cnt; base_str = strobe_cnt;
    push(32'h37, 32'hDEAD);
    wait_idle(20, "t4_idle_illegal");
    chk("t4_err_opcode", err_opcode, 1);
    chk("t4_no_strobe", strobe_cnt - base_str, 0);
    chk("t4_no_done", done_cnt - base_done, 0);
    exp_push(0, 14'd3, 32'h1234);
    push(32'h30, 32'h1234);
    wait_idle(20, "t4_idle_legal");
    chk("t4_next_done", done_cnt - base_done, 1);
    chk("t4_err_opcode_sticky", err_opcode, 1);
    clr_err = 1;
    @(negedge clk);
    clr_err = 0;
    chk("t4_errs_cleared", {err_opcode, err_overflow, err_timeout}, 0);

    // Reset while waiting for an ack with 3 entries queued.
    auto_ack = 0; base_done = done_cnt;
    exp_push(0, 14'd9, 32'h99);
    for (int i = 0; i < 4; i++) begin
      clk_en = 1;
      dataA  = (32'd9 + i) << 4;
      dataB  = 32'h99 + i;
      @(negedge clk);
    end
    clk_en = 0;
    repeat (2) @(negedge clk);
    chk("t5_level_before_reset", fifo_level, 3);
    chk("t5_busy_before_reset", busy, 1);
    base_str = strobe_cnt;
    reset = 0;
    #1 check_zero("t5_reset");
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    manual_reg_ack = 1;
    repeat (2) @(negedge clk);
    manual_reg_ack = 0;
    repeat (4) @(negedge clk);
    chk("t5_late_ack_no_done", done_cnt - base_done, 0);
    chk("t5_no_strobe_after_reset", strobe_cnt - base_str, 0);
    chk("t5_idle_after_reset", busy, 0);
    auto_ack = 1;

`ifdef VIDEO_CMD_ACK_TIMEOUT_EN
    auto_ack = 0; base_done = done_cnt;
    exp_push(1, 14'h22, 32'h5);
    push(32'h221, 32'h5);
    n = 0;
    while (!mem_wr && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t6_mem_wr_seen", mem_wr, 1);
    s_cyc = cyc;
    n = 0;
    while (!err_timeout && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("t6_err_timeout", err_timeout, 1);
    chk("t6_timeout_cycle", cyc - s_cyc, 17);
    chk("t6_back_to_idle", busy, 0);
    @(negedge clk);
    chk("t6_no_done", done_cnt - base_done, 0);
    auto_ack = 1;
`else
    chk("t6_timeout_tied_low", err_timeout, 0);
`endif

    chk("final_scoreboard_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
